// File: rtl/regfile_bypass_sb_pkg.sv
// Shared widths, types and helpers for the bypassing register file and its
// busy scoreboard.
package regfile_bypass_sb_pkg;

  localparam int WORD_W     = 16;
  localparam int NREGS      = 8;
  localparam int REG_IDX_W  = 3;
  localparam int BUSY_CNT_W = 4;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  function automatic logic [BUSY_CNT_W-1:0] popcount(input logic [NREGS-1:0] v);
    logic [BUSY_CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) begin
      c = c + BUSY_CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/regfile_bypass_sb_if.sv
// Read, write, issue and status bundle between decode (master) and the
// register file (slave).
interface regfile_bypass_sb_if
  import regfile_bypass_sb_pkg::*;
#(
  parameter int WIDTH = WORD_W
);

  reg_idx_t                rd0_idx;
  logic [WIDTH-1:0]        rd0_data;
  logic                    rd0_busy;
  reg_idx_t                rd1_idx;
  logic [WIDTH-1:0]        rd1_data;
  logic                    rd1_busy;
  logic                    wr_en;
  reg_idx_t                wr_idx;
  logic [WIDTH-1:0]        wr_data;
  logic                    wr_clr;
  logic                    iss_en;
  reg_idx_t                iss_idx;
  logic [BUSY_CNT_W-1:0]   busy_cnt;
  logic                    waw_err;

  modport master (
    output rd0_idx, rd1_idx, wr_en, wr_idx, wr_data, wr_clr, iss_en, iss_idx,
    input  rd0_data, rd0_busy, rd1_data, rd1_busy, busy_cnt, waw_err
  );

  modport slave (
    input  rd0_idx, rd1_idx, wr_en, wr_idx, wr_data, wr_clr, iss_en, iss_idx,
    output rd0_data, rd0_busy, rd1_data, rd1_busy, busy_cnt, waw_err
  );

endinterface

// File: rtl/regfile_bypass_sb_scoreboard.sv
// Per-register busy tracking: issue sets, clearing write releases, set wins;
// also counts busy registers and flags issue onto an already-busy register.
module regfile_scoreboard
  import regfile_bypass_sb_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic                  wr_clr_i,
  input  reg_idx_t              wr_idx_i,
  input  logic                  iss_en_i,
  input  reg_idx_t              iss_idx_i,
  input  reg_idx_t              rd0_idx_i,
  input  reg_idx_t              rd1_idx_i,
  output logic                  rd0_busy_o,
  output logic                  rd1_busy_o,
  output logic [BUSY_CNT_W-1:0] busy_cnt_o,
  output logic                  waw_err_o
);

  logic [NREGS-1:0]      busy_q, busy_d;
  logic [BUSY_CNT_W-1:0] busy_cnt_q;
  logic                  waw_err_q, waw_err_d;
  logic                  clr_any;

  assign clr_any = wr_en_i && wr_clr_i;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
    always_comb begin
      busy_d[gi] = busy_q[gi];
      if (iss_en_i && (iss_idx_i == reg_idx_t'(gi))) begin
        busy_d[gi] = 1'b1;
      end else if (clr_any && (wr_idx_i == reg_idx_t'(gi))) begin
        busy_d[gi] = 1'b0;
      end
    end
  end

  // A clear landing on the re-issued register this cycle means the old
  // producer retires, so the new issue is not a WAW hazard.
  assign waw_err_d = waw_err_q ||
                     (iss_en_i && busy_q[iss_idx_i] &&
                      !(clr_any && (wr_idx_i == iss_idx_i)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
      waw_err_q  <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= popcount(busy_d);
      waw_err_q  <= waw_err_d;
    end
  end

  assign rd0_busy_o = busy_q[rd0_idx_i] &&
                      !(BYPASS && clr_any && (wr_idx_i == rd0_idx_i));
  assign rd1_busy_o = busy_q[rd1_idx_i] &&
                      !(BYPASS && clr_any && (wr_idx_i == rd1_idx_i));
  assign busy_cnt_o = busy_cnt_q;
  assign waw_err_o  = waw_err_q;

endmodule

// File: rtl/regfile_bypass_sb.sv
// 8 x WIDTH register file with two combinational read ports, one write port,
// optional write-to-read forwarding and a busy scoreboard.
module regfile_bypass_sb
  import regfile_bypass_sb_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_bypass_sb_if.slave  bus
);

  logic [WIDTH-1:0] regs_q  [NREGS];
  reg_idx_t         rd_idx  [2];
  logic [WIDTH-1:0] rd_data [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (bus.wr_en) begin
      regs_q[bus.wr_idx] <= bus.wr_data;
    end
  end

  assign rd_idx[0] = bus.rd0_idx;
  assign rd_idx[1] = bus.rd1_idx;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    assign rd_data[gi] = (BYPASS && bus.wr_en && (bus.wr_idx == rd_idx[gi]))
                         ? bus.wr_data : regs_q[rd_idx[gi]];
  end

  assign bus.rd0_data = rd_data[0];
  assign bus.rd1_data = rd_data[1];

  regfile_scoreboard #(
    .BYPASS (BYPASS)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (bus.wr_en),
    .wr_clr_i   (bus.wr_clr),
    .wr_idx_i   (bus.wr_idx),
    .iss_en_i   (bus.iss_en),
    .iss_idx_i  (bus.iss_idx),
    .rd0_idx_i  (bus.rd0_idx),
    .rd1_idx_i  (bus.rd1_idx),
    .rd0_busy_o (bus.rd0_busy),
    .rd1_busy_o (bus.rd1_busy),
    .busy_cnt_o (bus.busy_cnt),
    .waw_err_o  (bus.waw_err)
  );

endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
8-entry x 16-bit register file with two asynchronous read ports, one synchronous write port and a per-register busy scoreboard. Sits directly upstream of the datapath's 8-input operand-select mux: its register array supplies the eight candidate words, and its read ports deliver the selected operands. Write-to-read bypass and busy tracking let decode detect and stall on RAW hazards without a separate hazard unit.

Parameters:
WIDTH, 16, data word width
NREGS, 8, number of registers (fixed at 8; index width 3)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns stored value

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rd0_idx  input  3  read port 0 register index
rd0_data  output  WIDTH  read port 0 data
rd0_busy  output  1  register at rd0_idx has a pending producer
rd1_idx  input  3  read port 1 register index
rd1_data  output  WIDTH  read port 1 data
rd1_busy  output  1  register at rd1_idx has a pending producer
wr_en  input  1  write strobe
wr_idx  input  3  write register index
wr_data  input  WIDTH  write data
wr_clr  input  1  with wr_en: clear busy bit of wr_idx
iss_en  input  1  issue strobe: mark iss_idx busy
iss_idx  input  3  destination register of issued instruction
busy_cnt  output  4  number of busy registers (0..8), registered
waw_err  output  1  sticky: issue to already-busy register occurred

Behaviour:
- One clock, clk; reset asynchronous, active-low on rst_n. Reset asserted: all regs <= 0, all busy bits <= 0, busy_cnt <= 0, waw_err <= 0, effective immediately without a clock edge. rd*_data read 0 and rd*_busy read 0 during and after reset until the first write/issue.
- Write: at posedge clk with wr_en=1, regs[wr_idx] <= wr_data. No write-enable gating by busy state.
- Read: combinational, zero latency. rd*_data = regs[rd*_idx], except when BYPASS=1 and wr_en=1 and wr_idx==rd*_idx, in which case rd*_data = wr_data. Both ports are independent; both may address the same or write register.
- Busy bits, next state per index i:
  - set if iss_en && iss_idx==i
  - else clear if wr_en && wr_clr && wr_idx==i
  - else hold.
  - Set and clear on the same index in the same cycle: set wins (new producer supersedes old).
- rd*_busy = busy[rd*_idx]; when BYPASS=1, additionally forced to 0 if wr_en && wr_clr && wr_idx==rd*_idx this cycle. The issue-set in the same cycle does not affect the read (visible next cycle).
- wr_en with wr_clr=0: data written, busy unchanged (partial/early write).
- wr_clr with wr_en=0: ignored.
- busy_cnt: registered popcount of next-state busy vector; updates at the same edge as the busy bits. Range 0..8; 4 bits, no wrap possible.
- waw_err: set at posedge clk when iss_en && busy[iss_idx] && !(clear of same index this cycle). Sticky until rst_n low.
- Reset asserted mid-operation (pending issues, in-flight writes): all state cleared; writes coincident with reset are lost.
- No X propagation: all indices are 3 bits, so every value is legal.

Decomposition:
- Shared package: WORD_W=16, NREGS=8, REG_IDX_W=3, BUSY_CNT_W=4; typedef word_t, reg_idx_t.
- Sub-module regfile_scoreboard: busy vector, set/clear priority, popcount, waw_err, and per-port busy lookup with clear-bypass. Top holds the data array and data bypass.

Test Plan:
- Reset: drive rst_n=0 mid-cycle after writing R3=0x1234 -> rd0_data(idx3)=0x0000, busy_cnt=0, waw_err=0 immediately, no clock needed.
- Write then read: write R5=0xBEEF at edge N; rd1_idx=5 after edge N -> rd1_data=0xBEEF. Before edge N, with BYPASS=1 -> 0xBEEF; with BYPASS=0 -> old value 0x0000.
- Scoreboard: iss R2 at edge 1 -> rd0_busy(2)=1, busy_cnt=1. wr_en+wr_clr R2=0x00AA in cycle 3 -> rd0_busy=0 and rd0_data=0x00AA that cycle (BYPASS=1); busy_cnt=0 after edge.
- Simultaneous: R4 busy; same cycle iss_idx=4 and wr_clr on 4 -> busy[4] stays 1, busy_cnt unchanged, waw_err stays 0.
- WAW: R6 busy, iss_idx=6 again with no clear -> waw_err=1 after edge and remains 1 across 10 further cycles until rst_n low.
- Fill: issue R0..R7 over 8 cycles -> busy_cnt steps 1..8. Clear all eight -> busy_cnt returns to 0.
